// File: rtl/gray_pkg.sv
// Shared constants and FIFO state encoding for the Gray-code transmitter.
package gray_pkg;

    localparam int GRAY_WIDTH   = 4;
    localparam int GRAY_MAX_VAL = 9;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } fifo_state_t;

endpackage

// File: rtl/gray_encoder_tx_bin_to_gray.sv
// Combinational binary-to-Gray converter: gray = bin ^ (bin >> 1).
module bin_to_gray #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray[WIDTH-1] = bin[WIDTH-1];

    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
            assign gray[gi] = bin[gi] ^ bin[gi+1];
        end
    endgenerate

endmodule

// File: rtl/gray_encoder_tx.sv
// Range-checked Gray encoder with a 2-entry output FIFO and saturating error count.
// Optional GRAY_ENC_PARITY_EN adds out_parity (XOR of out_gray) stored per entry.
module gray_encoder_tx
    import gray_pkg::*;
#(
    parameter int WIDTH   = GRAY_WIDTH,
    parameter int MAX_VAL = GRAY_MAX_VAL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gray,
    output logic             err_pulse,
    output logic [7:0]       err_count
`ifdef GRAY_ENC_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    fifo_state_t      state_reg, state_next;
    logic             in_ready_reg;
    logic             wr_ptr_reg, rd_ptr_reg;
    logic             err_pulse_reg;
    logic [7:0]       err_count_reg;
    logic [WIDTH-1:0] mem [2];
    logic [WIDTH-1:0] gray_in;
    logic             accept, in_range, push, reject, pop;

    bin_to_gray #(.WIDTH(WIDTH)) u_bin_to_gray (
        .bin  (in_bin),
        .gray (gray_in)
    );

    assign accept   = in_valid & in_ready_reg;
    assign in_range = (in_bin <= MAX_W);
    assign push     = accept & in_range;
    assign reject   = accept & ~in_range;
    assign out_valid = (state_reg != EMPTY);
    assign pop      = out_valid & out_ready;

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            EMPTY: if (push) state_next = HALF;
            HALF: begin
                if (push && !pop)      state_next = FULL;
                else if (pop && !push) state_next = EMPTY;
            end
            FULL:  if (pop) state_next = HALF;
            default: state_next = EMPTY;
        endcase
    end

    // in_ready is a flop loaded from the next state, so it mirrors state_reg != FULL
    // without any combinational path from out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= EMPTY;
            in_ready_reg  <= 1'b0;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            err_pulse_reg <= 1'b0;
            err_count_reg <= 8'd0;
        end else begin
            state_reg     <= state_next;
            in_ready_reg  <= (state_next != FULL);
            err_pulse_reg <= reject;
            if (push)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
            if (reject && err_count_reg != 8'hFF)
                err_count_reg <= err_count_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= gray_in;
    end

    // Entries are not reset; gating with out_valid keeps the outputs at zero when empty.
    assign in_ready  = in_ready_reg;
    assign out_gray  = out_valid ? mem[rd_ptr_reg] : '0;
    assign err_pulse = err_pulse_reg;
    assign err_count = err_count_reg;

`ifdef GRAY_ENC_PARITY_EN
    logic par_mem [2];

    always_ff @(posedge clk) begin
        if (push)
            par_mem[wr_ptr_reg] <= ^gray_in;
    end

    assign out_parity = out_valid & par_mem[rd_ptr_reg];
`endif

endmodule

// File: tb/tb_gray_encoder_tx.sv
// Directed self-checking bench for gray_encoder_tx (covers GRAY_ENC_PARITY_EN when defined).
module tb_gray_encoder_tx;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_bin;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_gray;
    logic       err_pulse;
    logic [7:0] err_count;
`ifdef GRAY_ENC_PARITY_EN
    logic       out_parity;
`endif

    int n_compared;
    int n_mismatched;

    gray_encoder_tx #(.WIDTH(4), .MAX_VAL(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gray  (out_gray),
        .err_pulse (err_pulse),
        .err_count (err_count)
`ifdef GRAY_ENC_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bin    = 4'd0;
        out_ready = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check_value("rst_in_ready",  32'(in_ready),  32'd0);
        check_value("rst_out_valid", 32'(out_valid), 32'd0);
        check_value("rst_out_gray",  32'(out_gray),  32'd0);
        check_value("rst_err_pulse", 32'(err_pulse), 32'd0);
        check_value("rst_err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        tick();
        check_value("in_ready_after_rst", 32'(in_ready), 32'd1);

        // 0110 -> 0101, one cycle latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_bin    = 4'b0110;
        tick();
        in_valid = 1'b0;
        check_value("enc6_valid",     32'(out_valid), 32'd1);
        check_value("enc6_gray",      32'(out_gray),  32'b0101);
        check_value("enc6_err_pulse", 32'(err_pulse), 32'd0);
        tick();
        check_value("enc6_drained", 32'(out_valid), 32'd0);

        // 1001 in range -> 1101; 1100 out of range -> rejected
        in_valid = 1'b1;
        in_bin   = 4'b1001;
        tick();
        in_valid = 1'b0;
        check_value("enc9_gray", 32'(out_gray), 32'b1101);
        tick();
        in_valid = 1'b1;
        in_bin   = 4'b1100;
        tick();
        in_valid = 1'b0;
        check_value("rej12_no_out",    32'(out_valid), 32'd0);
        check_value("rej12_err_pulse", 32'(err_pulse), 32'd1);
        check_value("rej12_err_count", 32'(err_count), 32'd1);
        tick();
        check_value("rej12_pulse_drop", 32'(err_pulse), 32'd0);
        check_value("rej12_still_none", 32'(out_valid), 32'd0);

        // Back-pressure: fill to FULL, third word waits
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_bin    = 4'b0001;
        tick();
        check_value("bp_half_ready", 32'(in_ready), 32'd1);
        in_bin = 4'b0010;
        tick();
        check_value("bp_full_ready", 32'(in_ready), 32'd0);
        in_bin = 4'b0011;
        tick();
        check_value("bp_still_full", 32'(in_ready), 32'd0);
        check_value("bp_head_stable", 32'(out_gray), 32'b0001);
        out_ready = 1'b1;
        tick();
        check_value("bp_second_word", 32'(out_gray), 32'b0011);
        check_value("bp_ready_back",  32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check_value("bp_third_word", 32'(out_gray),  32'b0010);
        check_value("bp_third_vld",  32'(out_valid), 32'd1);
        tick();
        check_value("bp_empty", 32'(out_valid), 32'd0);

        // 256 rejects starting from err_count=1
        in_valid = 1'b1;
        in_bin   = 4'b1111;
        for (int i = 0; i < 100; i++) tick();
        check_value("sat_mid_count", 32'(err_count), 32'd101);
        for (int i = 100; i < 256; i++) tick();
        in_valid = 1'b0;
        check_value("sat_count",     32'(err_count), 32'd255);
        check_value("sat_pulse",     32'(err_pulse), 32'd1);
        check_value("sat_no_output", 32'(out_valid), 32'd0);
        tick();
        check_value("sat_hold", 32'(err_count), 32'd255);

        // Reset while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_bin    = 4'b0100;
        tick();
        in_bin = 4'b0101;
        tick();
        in_valid = 1'b0;
        check_value("pre_rst_full", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_value("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_value("mid_rst_err_count", 32'(err_count), 32'd0);
        check_value("mid_rst_out_gray",  32'(out_gray),  32'd0);
        check_value("mid_rst_in_ready",  32'(in_ready),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check_value("post_rst_ready", 32'(in_ready),  32'd1);
        check_value("post_rst_empty", 32'(out_valid), 32'd0);
        tick();
        check_value("post_rst_no_stale", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        in_bin   = 4'b0111;
        tick();
        in_valid = 1'b0;
        check_value("post_rst_fresh", 32'(out_gray), 32'b0100);
        tick();

`ifdef GRAY_ENC_PARITY_EN
        in_valid = 1'b1;
        in_bin   = 4'b0110;
        tick();
        in_valid = 1'b0;
        check_value("par6_gray",   32'(out_gray),   32'b0101);
        check_value("par6_parity", 32'(out_parity), 32'd0);
        tick();
        in_valid = 1'b1;
        in_bin   = 4'b0001;
        tick();
        in_valid = 1'b0;
        check_value("par1_gray",   32'(out_gray),   32'b0001);
        check_value("par1_parity", 32'(out_parity), 32'd1);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/gray_encoder_tx.md
GRAY_ENCODER_TX -- requirements
Module: gray_encoder_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the code word width in bits.
REQ-002 The block SHALL have parameter MAX_VAL, default 9, meaning the largest binary value accepted for encoding.
REQ-003 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid  input  1  producer offers in_bin.
REQ-006 The block SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-007 The block SHALL have port in_bin  input  WIDTH  binary word to encode.
REQ-008 The block SHALL have port out_valid  output  1  out_gray holds a valid word.
REQ-009 The block SHALL have port out_ready  input  1  consumer takes out_gray this cycle.
REQ-010 The block SHALL have port out_gray  output  WIDTH  Gray-coded word, bin ^ (bin >> 1).
REQ-011 The block SHALL have port err_pulse  output  1  one-cycle flag marking a rejected out-of-range word.
REQ-012 The block SHALL have port err_count  output  8  saturating count of rejected words.

Function
REQ-013 The block SHALL transfer an input word only on a rising clk edge where in_valid and in_ready are both 1, and an output word only where out_valid and out_ready are both 1.
REQ-014 The block SHALL forward only words with in_bin <= MAX_VAL; an accepted word with in_bin > MAX_VAL SHALL be consumed, dropped, SHALL raise err_pulse on the next cycle, and SHALL increment err_count.
REQ-015 err_count SHALL saturate at 255 and never wrap.
REQ-016 The block SHALL store forwarded words in a 2-entry FIFO tracked by the states EMPTY, HALF and FULL.
REQ-017 FIFO transitions: EMPTY+push->HALF; HALF+push only->FULL; HALF+pop only->EMPTY; HALF+push+pop->HALF; FULL+pop->HALF; any other combination SHALL hold the current state.
REQ-018 in_ready SHALL equal (state != FULL) and SHALL be driven from registered state only, with no combinational path from out_ready.
REQ-019 out_valid SHALL equal (state != EMPTY), and out_gray SHALL present the oldest stored word.
REQ-020 Latency from input acceptance to out_valid SHALL be exactly 1 cycle when the FIFO is EMPTY.
REQ-021 Words SHALL leave in acceptance order with no loss or duplication under any out_ready pattern.
REQ-022 out_gray SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 In FULL, an in_valid word SHALL NOT be accepted, including a rejected out-of-range word.

Reset
REQ-024 Asserting rst_n=0 SHALL immediately force state=EMPTY, in_ready=0, out_valid=0, out_gray=0, err_pulse=0 and err_count=0.
REQ-025 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-026 Reset in mid-operation SHALL discard all buffered words.

Configuration
REQ-027 With GRAY_ENC_PARITY_EN defined, the block SHALL add port out_parity  output  1, equal to the XOR of out_gray and stored alongside each FIFO entry (0 in reset).
REQ-028 Without GRAY_ENC_PARITY_EN, out_parity SHALL NOT exist and no parity storage SHALL be synthesized.

Structure
REQ-029 Package gray_pkg SHALL hold the WIDTH and MAX_VAL default constants and the FIFO state enum fifo_state_t (EMPTY, HALF, FULL).
REQ-030 The binary-to-Gray conversion SHALL be a combinational sub-module bin_to_gray, instantiated once at the FIFO input.

Verification
REQ-031 Bench SHALL drive in_bin=0110 with out_ready=1 and check out_gray=0101 one cycle later, err_pulse=0.
REQ-032 Bench SHALL drive in_bin=1001 and check out_gray=1101; it SHALL then drive in_bin=1100 and check that no output appears, err_pulse=1 for one cycle, and err_count=1.
REQ-033 Bench SHALL hold out_ready=0 and offer 0001, 0010, 0011, checking that in_ready=0 after two pushes; on releasing out_ready it SHALL check outputs 0001 then 0011 in order and that 0011 is then accepted.
REQ-034 Bench SHALL push 256 out-of-range words (in_bin=1111) and check that err_count holds at 255 and does not wrap.
REQ-035 Bench SHALL assert rst_n=0 with FULL occupancy and check out_valid=0 and err_count=0 immediately, with no stale words after release.
REQ-036 With GRAY_ENC_PARITY_EN defined, bench SHALL check that in_bin=0110 gives out_gray=0101 with out_parity=0, and in_bin=0001 gives out_gray=0001 with out_parity=1.
